// File: rtl/wb_stage_buffer.sv
// wb_stage_buffer: DEPTH-entry elastic writeback stage between EX/MEM and WB.
// Each entry holds a data word and its hazard tag. Upstream and downstream use
// valid/ready handshakes. The stage also supports flush, stall and occupancy
// reporting. BYPASS=1 lets a word pass through combinationally when the stage
// is empty and the word is taken in the same cycle. BYPASS=0 always registers
// the word, which adds one cycle of latency.
// Optional feature: define WB_STAGE_STATS_EN to add the stall_cycles output.
// It is a saturating count of cycles in which a valid output was held back.
// The reset port 'rst' is asynchronous and active-low.
`timescale 1ns/1ps

module wb_stage_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HAZ_W  = 2,
  parameter int unsigned DEPTH  = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HAZ_W-1:0]  in_hazard,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HAZ_W-1:0]  out_hazard,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
`ifdef WB_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef struct packed {
    logic [HAZ_W-1:0]  hazard;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   empty;
  logic   not_full;
  logic   bypass_sel;
  logic   push;
  logic   pop;
  logic   wr_en;
  logic   rd_en;
  entry_t head;

  // Advance a circular pointer. DEPTH need not be a power of two, so the
  // pointer wraps explicitly instead of relying on natural overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign not_full = (count_q < CNT_W'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Handshake and output selection. The reset input is also used as a gate
  // here, so both sides stay quiet while reset is held even if in_valid is high.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first; a path that leaves one unassigned infers a latch.
    bypass_sel = BYPASS && empty && in_valid && rst && !stall && !flush;
    in_ready   = rst && not_full && !stall && !flush;
    out_valid  = 1'b0;
    out_data   = head.data;
    out_hazard = head.hazard;
    if (!empty) begin
      // A stored head stays valid through a stall. Only flush or reset hides it.
      out_valid = rst && !flush;
    end else if (bypass_sel) begin
      out_valid  = 1'b1;
      out_data   = in_data;
      out_hazard = in_hazard;
    end
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready && !stall && !flush;
    // A bypassed word taken in the same cycle never touches storage.
    wr_en = push && !(bypass_sel && out_ready);
    rd_en = pop && !empty;
  end

  // Next-state logic for the pointers, the occupancy count and the storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = '{hazard: in_hazard, data: in_data};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_en) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers. Stall needs no term here: push and pop are both zero
  // during a stall, so the _d values already equal the _q values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is reset explicitly so the head never drives X on an empty stage; this costs reset fan-out on every entry.
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values, independent of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

`ifdef WB_STAGE_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Count cycles in which a valid word is held back, saturating at all-ones.
  // Only reset clears this counter; flush leaves it alone.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (out_valid && (!out_ready || stall) && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Stall statistics register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_wb_stage_buffer.sv
// tb_wb_stage_buffer: scoreboard bench for wb_stage_buffer.
// dut_b: DEPTH=2, BYPASS=1.
// dut_r: DEPTH=3, BYPASS=0, non-power-of-two wrap.
// The monitor records each accepted input word and compares every output
// handshake in order. Directed checks cover count, in_ready and the
// reset, stall and flush behaviour.
`timescale 1ns/1ps

module tb_wb_stage_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef logic [33:0] word_t;
  word_t exp_b[$];
  word_t exp_r[$];

  // Bypass instance signals
  logic        b_flush, b_stall, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_in_hazard, b_out_hazard, b_count;
  logic [31:0] b_in_data, b_out_data;
  // Registered instance signals
  logic        r_flush, r_stall, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [1:0]  r_in_hazard, r_out_hazard, r_count;
  logic [31:0] r_in_data, r_out_data;
`ifdef WB_STAGE_STATS_EN
  logic [15:0] b_stall_cycles, r_stall_cycles;
`endif

  wb_stage_buffer #(.DATA_W(32), .HAZ_W(2), .DEPTH(2), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .stall(b_stall),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_hazard(b_in_hazard), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_hazard(b_out_hazard), .out_data(b_out_data),
    .count(b_count)
`ifdef WB_STAGE_STATS_EN
    , .stall_cycles(b_stall_cycles)
`endif
  );

  wb_stage_buffer #(.DATA_W(32), .HAZ_W(2), .DEPTH(3), .BYPASS(1'b0)) dut_r (
    .clk(clk), .rst(rst), .flush(r_flush), .stall(r_stall),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_hazard(r_in_hazard), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_hazard(r_out_hazard), .out_data(r_out_data),
    .count(r_count)
`ifdef WB_STAGE_STATS_EN
    , .stall_cycles(r_stall_cycles)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle. Accepted inputs are queued first,
  // so a word bypassed in the same cycle is already present when popped.
  always @(negedge clk) begin
    if (!rst) begin
      exp_b.delete();
      exp_r.delete();
    end else begin
      if (b_in_valid && b_in_ready) exp_b.push_back({b_in_hazard, b_in_data});
      if (b_out_valid && b_out_ready && !b_stall && !b_flush) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_out: got %0h expected none", b_out_data);
        end else begin
          check("b_out", 64'({b_out_hazard, b_out_data}), 64'(exp_b.pop_front()));
        end
      end
      if (b_flush) exp_b.delete();
      if (r_in_valid && r_in_ready) exp_r.push_back({r_in_hazard, r_in_data});
      if (r_out_valid && r_out_ready && !r_stall && !r_flush) begin
        if (exp_r.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected_out: got %0h expected none", r_out_data);
        end else begin
          check("r_out", 64'({r_out_hazard, r_out_data}), 64'(exp_r.pop_front()));
        end
      end
      if (r_flush) exp_r.delete();
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    b_flush = 0; b_stall = 0; b_in_valid = 1; b_in_hazard = 2'b10; b_in_data = 32'hDEADBEEF; b_out_ready = 1;
    r_flush = 0; r_stall = 0; r_in_valid = 1; r_in_hazard = 2'b01; r_in_data = 32'h12345678; r_out_ready = 1;
    #1 rst = 1'b0;
    #2;
    // Reset state with live inputs: everything quiet and zero
    check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    check("rst_b_in_ready",  64'(b_in_ready),  64'(0));
    check("rst_b_out_data",  64'(b_out_data),  64'(0));
    check("rst_b_out_haz",   64'(b_out_hazard), 64'(0));
    check("rst_b_count",     64'(b_count),     64'(0));
    check("rst_r_out_valid", 64'(r_out_valid), 64'(0));
    check("rst_r_in_ready",  64'(r_in_ready),  64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; b_in_valid = 0; r_in_valid = 0;
    #1;
    check("post_rst_b_in_ready", 64'(b_in_ready), 64'(1));

    // 1: zero-latency bypass
    tick(); b_in_valid = 1; b_in_data = 32'hDEADBEEF; b_in_hazard = 2'b10; b_out_ready = 1;
    #1;
    check("byp_out_valid", 64'(b_out_valid), 64'(1));
    check("byp_out_data",  64'(b_out_data),  64'(32'hDEADBEEF));
    check("byp_out_haz",   64'(b_out_hazard), 64'(2'b10));
    tick(); b_in_valid = 0;
    #1;
    check("byp_count", 64'(b_count), 64'(0));
    check("byp_idle_valid", 64'(b_out_valid), 64'(0));

    // 2: fill to full, third word held upstream, then drain in order
    tick(); b_out_ready = 0; b_in_valid = 1; b_in_data = 32'h11; b_in_hazard = 2'd1;
    #1;
    check("fill_bypass_visible", 64'(b_out_valid), 64'(1));
    tick(); b_in_data = 32'h22; b_in_hazard = 2'd2;
    #1;
    check("fill_count1", 64'(b_count), 64'(1));
    check("fill_head", 64'(b_out_data), 64'(32'h11));
    tick(); b_in_data = 32'h33; b_in_hazard = 2'd3;
    #1;
    check("full_count", 64'(b_count), 64'(2));
    check("full_in_ready", 64'(b_in_ready), 64'(0));
    tick();
    check("full_hold_count", 64'(b_count), 64'(2));
    b_out_ready = 1;
    #1;
    check("full_pop_no_push", 64'(b_in_ready), 64'(0));
    tick();
    check("drain_count", 64'(b_count), 64'(1));
    check("drain_in_ready", 64'(b_in_ready), 64'(1));
    check("drain_head", 64'(b_out_data), 64'(32'h22));
    tick(); b_in_valid = 0;
    #1;
    check("drain_third", 64'(b_out_data), 64'(32'h33));
    tick();
    check("drain_empty", 64'(b_count), 64'(0));

    // 4: stall freezes a full stage, then FIFO order resumes
    tick(); b_out_ready = 0; b_in_valid = 1; b_in_data = 32'h44; b_in_hazard = 2'd0;
    tick(); b_in_data = 32'h55; b_in_hazard = 2'd1;
    tick(); b_in_data = 32'h66; b_in_hazard = 2'd2; b_stall = 1; b_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      check("stall_count", 64'(b_count), 64'(2));
      check("stall_in_ready", 64'(b_in_ready), 64'(0));
      check("stall_data", 64'(b_out_data), 64'(32'h44));
      check("stall_valid", 64'(b_out_valid), 64'(1));
    end
    tick(); b_stall = 0;
    #1;
    check("unstall_in_ready", 64'(b_in_ready), 64'(0));
    tick();
    check("unstall_count", 64'(b_count), 64'(1));
    check("unstall_head", 64'(b_out_data), 64'(32'h55));
    tick(); b_in_valid = 0;
    #1;
    check("unstall_third", 64'(b_out_data), 64'(32'h66));
    tick();
    check("unstall_empty", 64'(b_count), 64'(0));

    // 5: flush drops stored words and the flush-cycle input
    tick(); b_out_ready = 0; b_in_valid = 1; b_in_data = 32'h77; b_in_hazard = 2'd3;
    tick(); b_in_data = 32'h88; b_in_hazard = 2'd0;
    tick(); b_flush = 1; b_in_data = 32'h99; b_in_hazard = 2'd1; b_out_ready = 1;
    #1;
    check("flush_out_valid", 64'(b_out_valid), 64'(0));
    check("flush_in_ready", 64'(b_in_ready), 64'(0));
    tick(); b_flush = 0; b_in_valid = 0;
    #1;
    check("post_flush_count", 64'(b_count), 64'(0));
    check("post_flush_valid", 64'(b_out_valid), 64'(0));
    tick(); b_in_valid = 1; b_in_data = 32'hAA; b_in_hazard = 2'd2;
    #1;
    check("post_flush_stream", 64'(b_out_data), 64'(32'hAA));
    tick(); b_in_valid = 0;

    // 3: registered mode has one cycle of latency
    tick(); r_out_ready = 1; r_in_valid = 1; r_in_data = 32'hA5A5A5A5; r_in_hazard = 2'd1;
    #1;
    check("reg_push_cycle_valid", 64'(r_out_valid), 64'(0));
    check("reg_in_ready", 64'(r_in_ready), 64'(1));
    tick(); r_in_valid = 0;
    #1;
    check("reg_next_valid", 64'(r_out_valid), 64'(1));
    check("reg_next_data", 64'(r_out_data), 64'(32'hA5A5A5A5));
    check("reg_count1", 64'(r_count), 64'(1));
    tick();
    check("reg_empty_valid", 64'(r_out_valid), 64'(0));

    // Streaming through DEPTH=3 wraps the pointers past the end
    for (int i = 0; i < 6; i++) begin
      tick(); r_in_valid = 1; r_in_data = 32'h1000 + 32'(i); r_in_hazard = 2'(i);
      #1;
      check("stream_in_ready", 64'(r_in_ready), 64'(1));
    end
    tick(); r_in_valid = 0;
    tick();
    check("stream_empty", 64'(r_count), 64'(0));

    // Fill DEPTH=3 with wrapped pointers, then drain
    r_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); r_in_valid = 1; r_in_data = 32'h2000 + 32'(i); r_in_hazard = 2'(3 - i);
    end
    tick(); r_in_data = 32'h2003;
    #1;
    check("reg_full_count", 64'(r_count), 64'(3));
    check("reg_full_in_ready", 64'(r_in_ready), 64'(0));
    check("reg_full_head", 64'(r_out_data), 64'(32'h2000));
    r_in_valid = 0; r_out_ready = 1;
    tick(); check("reg_drain2", 64'(r_count), 64'(2));
    tick(); check("reg_drain1", 64'(r_count), 64'(1));
    tick(); check("reg_drain0", 64'(r_count), 64'(0));

    // 6: asynchronous reset mid-stream
    tick(); b_out_ready = 0; b_in_valid = 1; b_in_data = 32'hBB; b_in_hazard = 2'd1;
    tick(); b_in_valid = 0;
    #1;
    check("pre_rst_count", 64'(b_count), 64'(1));
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(b_out_valid), 64'(0));
    check("arst_out_data", 64'(b_out_data), 64'(0));
    check("arst_out_haz", 64'(b_out_hazard), 64'(0));
    check("arst_count", 64'(b_count), 64'(0));
`ifdef WB_STAGE_STATS_EN
    check("arst_b_stats", 64'(b_stall_cycles), 64'(0));
    check("arst_r_stats", 64'(r_stall_cycles), 64'(0));
`endif
    @(posedge clk); #1 rst = 1'b1; b_out_ready = 1;

`ifdef WB_STAGE_STATS_EN
    tick(); r_out_ready = 0; r_in_valid = 1; r_in_data = 32'h3000; r_in_hazard = 2'd2;
    tick(); r_in_valid = 0;
    check("stats_start", 64'(r_stall_cycles), 64'(0));
    repeat (10) tick();
    check("stats_ten", 64'(r_stall_cycles), 64'(10));
    repeat (65530) tick();
    check("stats_sat", 64'(r_stall_cycles), 64'(16'hFFFF));
    tick();
    check("stats_hold_sat", 64'(r_stall_cycles), 64'(16'hFFFF));
    r_out_ready = 1;
    tick();
    check("stats_drain", 64'(r_count), 64'(0));
`endif

    tick();
    check("b_queue_empty", 64'(exp_b.size()), 64'(0));
    check("r_queue_empty", 64'(exp_r.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage_buffer.md
Name: wb_stage_buffer

Overview:
Parametrised successor to the writeback-data stage register. It is a DEPTH-entry elastic stage between EX/MEM and WB that carries a data word plus hazard tag. It replaces the single hold-on-stall register with a valid/ready handshake, flush, occupancy reporting, and a selectable zero-latency bypass or registered mode. It sits in front of the register-file write port and the forwarding network.

Parameters:
DATA_W, 32, width of writeback data
HAZ_W, 2, width of hazard tag travelling with data
DEPTH, 2, number of storage entries (legal 1..8)
BYPASS, 1, 1 = combinational pass-through when empty; 0 = always registered (1-cycle latency)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  discard all stored entries and the current input
stall  in  1  freeze: no push, no pop, outputs held
in_valid  in  1  upstream has a word
in_ready  out  1  stage can accept a word
in_hazard  in  HAZ_W  hazard tag of input word
in_data  in  DATA_W  input data word
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
out_hazard  out  HAZ_W  hazard tag of head word
out_data  out  DATA_W  head data word
count  out  $clog2(DEPTH+1)  stored entries, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries {hazard,data}; wr_ptr/rd_ptr wrap from DEPTH-1 to 0 (DEPTH need not be a power of two).
- in_ready = (count < DEPTH) & ~stall & ~flush.
- in_ready never depends on out_ready: no push at full even when a pop occurs in the same cycle.
- push = in_valid & in_ready.
- pop = out_valid & out_ready & ~stall & ~flush.
- Output selection:
  - count>0: out_* = head entry.
  - count==0, BYPASS=1: out_valid=in_valid & ~stall & ~flush, out_data=in_data, out_hazard=in_hazard.
  - count==0, BYPASS=0: out_valid=0.
- Bypass case (BYPASS=1, count==0, in_valid, accepted same cycle): word passes through with zero latency. No storage write, count stays 0.
- Bypass case (BYPASS=1, count==0, in_valid, not accepted): word is written to storage and count becomes 1.
- BYPASS=0: every word is stored first; earliest out_valid is the cycle after push. Latency 1.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, pointers both advance.
- Ordering is strict FIFO; no word is dropped or duplicated except by flush.
- stall=1: pointers, count and storage are frozen; out_* hold their previous values; in_ready=0. In stored mode out_valid stays as is.
- flush=1: count, wr_ptr and rd_ptr clear to 0 at the clock edge. The input word in that cycle is discarded. out_valid=0 combinationally during the flush cycle. flush has priority over stall.
- Reset (rst=0, asynchronous): count=0, pointers=0, storage cleared to 0.
  - During reset: out_valid=0, out_data=0, out_hazard=0, in_ready=0.
  - First handshake is possible in the first cycle after rst rises.
- Reset asserted mid-transfer aborts all stored words; there is no recovery of contents.
- Empty with in_valid=0: out_data/out_hazard are don't-care but must not be X after reset. Drive the stored head, which is 0 after reset.

Optional Feature:
WB_STAGE_STATS_EN: adds output stall_cycles[15:0]. It counts cycles with out_valid=1 & (out_ready=0 | stall=1) and saturates at 16'hFFFF. It is cleared only by rst, not by flush.
Without the macro, the port and counter are absent. Core behaviour is identical either way.

Test Plan:
1. BYPASS=1, empty, in_valid=1, in_data=32'hDEADBEEF, in_hazard=2'b10, out_ready=1 -> same cycle out_valid=1, out_data=32'hDEADBEEF, out_hazard=2'b10; count stays 0.
2. DEPTH=2, out_ready=0, push 32'h11 then 32'h22 -> count=2, in_ready=0. Third word 32'h33 is held upstream. With out_ready=1, outputs 32'h11 then 32'h22, then 32'h33 is accepted.
3. BYPASS=0, single push 32'hA5A5A5A5 -> out_valid=0 in push cycle; out_valid=1 with 32'hA5A5A5A5 next cycle.
4. count=2, stall=1 for 3 cycles with out_ready=1, in_valid=1 -> out_data held, count=2, in_ready=0. After stall drops, FIFO order resumes.
5. count=2, flush=1 with in_valid=1 -> out_valid=0 that cycle; next cycle count=0 and the flush-cycle input is absent from the output stream.
6. rst pulled low mid-stream with count=1 -> out_valid, out_data, out_hazard and count go to 0 immediately (asynchronously). With WB_STAGE_STATS_EN, stall_cycles=0 and later saturates at 16'hFFFF under continuous backpressure.
